// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_control_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int INSTR_BITS = 32;
  localparam int PC_STEP    = 4;

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry valid/ready output register holding {instr, instr_pc}; flush wins over load.
module fetch_out_buffer
  import fetch_control_pkg::*;
#(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    load,
  input  logic [INSTR_BITS-1:0]   load_instr,
  input  logic [ADDRESS_BITS-1:0] load_pc,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [INSTR_BITS-1:0]   out_instr,
  output logic [ADDRESS_BITS-1:0] out_pc
);

  logic                    valid_reg;
  logic [INSTR_BITS-1:0]   instr_reg;
  logic [ADDRESS_BITS-1:0] pc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= load_instr;
      pc_reg    <= load_pc;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_instr = instr_reg;
  assign out_pc    = pc_reg;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: PC advance/hold/redirect, imem handshake, decode output buffer.
// Optional FETCH_CONTROL_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int                    ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic [INSTR_BITS-1:0]   imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_BITS-1:0]   instr,
  output logic [ADDRESS_BITS-1:0] instr_pc
`ifdef FETCH_CONTROL_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_stall
`endif
);

  state_t                  state_reg, state_next;
  logic                    pend_valid_reg, pend_valid_next;
  logic [ADDRESS_BITS-1:0] pend_target_reg, pend_target_next;
  logic [INSTR_BITS-1:0]   side_instr_reg;
  logic [ADDRESS_BITS-1:0] side_pc_reg;

  logic                    drain;
  logic                    side_load;
  logic                    buf_flush;
  logic                    buf_load;
  logic [INSTR_BITS-1:0]   buf_load_instr;
  logic [ADDRESS_BITS-1:0] buf_load_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= BOOT;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      side_instr_reg  <= '0;
      side_pc_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      if (side_load) begin
        side_instr_reg <= imem_rdata;
        side_pc_reg    <= PC;
      end
    end
  end

  always_comb begin
    drain            = instr_valid && instr_ready;
    state_next       = state_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    next_PC_select   = 1'b1;
    target_PC        = PC;
    imem_req         = 1'b0;
    imem_addr        = PC;
    side_load        = 1'b0;
    buf_flush        = 1'b0;
    buf_load         = 1'b0;
    buf_load_instr   = imem_rdata;
    buf_load_pc      = PC;

    case (state_reg)
      BOOT: begin
        state_next = REQ;
        if (redirect_valid) begin
          target_PC = redirect_target;
          buf_flush = 1'b1;
        end else begin
          target_PC = RESET_PC;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid && imem_ready) begin
          target_PC       = redirect_target;
          buf_flush       = 1'b1;
          pend_valid_next = 1'b0;
        end else if (redirect_valid) begin
          // Request in flight: keep PC/address stable, remember the target,
          // and drop already-buffered younger instructions now.
          pend_valid_next  = 1'b1;
          pend_target_next = redirect_target;
          buf_flush        = 1'b1;
        end else if (imem_ready && pend_valid_reg) begin
          target_PC       = pend_target_reg;
          pend_valid_next = 1'b0;
        end else if (imem_ready && (!instr_valid || drain)) begin
          buf_load       = 1'b1;
          next_PC_select = 1'b0;
        end else if (imem_ready) begin
          side_load  = 1'b1;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          target_PC  = redirect_target;
          buf_flush  = 1'b1;
          state_next = REQ;
        end else if (!instr_valid || drain) begin
          buf_load       = 1'b1;
          buf_load_instr = side_instr_reg;
          buf_load_pc    = side_pc_reg;
          next_PC_select = 1'b0;
          state_next     = REQ;
        end
      end

      default: state_next = BOOT;
    endcase
  end

  fetch_out_buffer #(
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_out_buffer (
    .clock     (clock),
    .reset     (reset),
    .flush     (buf_flush),
    .load      (buf_load),
    .load_instr(buf_load_instr),
    .load_pc   (buf_load_pc),
    .out_ready (instr_ready),
    .out_valid (instr_valid),
    .out_instr (instr),
    .out_pc    (instr_pc)
  );

`ifdef FETCH_CONTROL_PERF_EN
  logic [31:0] fetched_reg;
  logic [31:0] stall_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_reg <= '0;
      stall_reg   <= '0;
    end else begin
      if (buf_load) fetched_reg <= fetched_reg + 32'd1;
      if ((state_reg == REQ && !imem_ready) || state_reg == HOLD)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign perf_fetched = fetched_reg;
  assign perf_stall   = stall_reg;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Randomized scoreboard bench for fetch_control: program-order stream model plus redirect timing rules.
module tb_fetch_control;

  localparam int            AB     = 16;
  localparam logic [AB-1:0] RST_PC = 16'h0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AB-1:0] PC = 16'hBEEF;
  logic          next_PC_select;
  logic [AB-1:0] target_PC;
  logic          imem_req;
  logic [AB-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [AB-1:0] redirect_target = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [AB-1:0] instr_pc;
`ifdef FETCH_CONTROL_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  fetch_control #(
    .ADDRESS_BITS(AB),
    .RESET_PC    (RST_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_CONTROL_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // Behaviour of the fetch stage's PC register.
  always @(posedge clock) PC <= next_PC_select ? target_PC : PC + 16'd4;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;

  function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  int            lat_min = 0, lat_max = 0, rdy_pct = 100, redir_pct = 0;
  bit            redir_on_wait = 0;
  logic [AB-1:0] redir_on_wait_tgt = '0;
  bit            mem_busy = 0;
  int            mem_wait = 0;

  task automatic step(input bit force_redir, input logic [AB-1:0] tgt);
    logic [AB-1:0] rnd;
    @(negedge clock);
    imem_ready = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = $urandom_range(lat_max, lat_min);
      end
      if (mem_wait == 0) begin
        imem_ready = 1'b1;
        mem_busy   = 0;
      end else begin
        mem_wait--;
      end
    end
    imem_rdata  = mem_word(imem_addr);
    instr_ready = ($urandom_range(99, 0) < rdy_pct);
    rnd = AB'($urandom_range(65535, 0));
    if ($urandom_range(3, 0) == 0) rnd = 16'hFFF0 | {12'h0, rnd[3:0]};
    redirect_valid  = force_redir || ($urandom_range(99, 0) < redir_pct);
    redirect_target = force_redir ? tgt : rnd;
    if (redir_on_wait && imem_req && !imem_ready) begin
      redirect_valid  = 1'b1;
      redirect_target = redir_on_wait_tgt;
      redir_on_wait   = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
    check({tag, "_next_PC_select"}, 32'(next_PC_select), 32'd1);
    check({tag, "_target_PC"}, 32'(target_PC), 32'(RST_PC));
`ifdef FETCH_CONTROL_PERF_EN
    check({tag, "_perf_fetched"}, perf_fetched, 32'd0);
    check({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
  endtask

  initial begin
    bit found;
    // Reset and zero-wait streaming.
    repeat (3) @(negedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("boot_imem_req", 32'(imem_req), 32'd0);
    check("boot_target_PC", 32'(target_PC), 32'(RST_PC));
    for (int k = 0; k < 3; k++) begin
      step(0, '0);
      #1;
      check("stream_imem_req", 32'(imem_req), 32'd1);
      check("stream_imem_addr", 32'(imem_addr), 32'(RST_PC) + 32'(4 * k));
      if (k > 0) begin
        check("stream_instr_valid", 32'(instr_valid), 32'd1);
        check("stream_instr_pc", 32'(instr_pc), 32'(RST_PC) + 32'(4 * (k - 1)));
      end
    end

    // Decode stalls: next response parks in HOLD, then drains in order.
    rdy_pct = 0;
    step(0, '0);
    step(0, '0);
    #1 check("hold_imem_req", 32'(imem_req), 32'd0);
    step(0, '0);
    step(0, '0);
    rdy_pct = 100;
    repeat (6) step(0, '0);

    // Redirect while parked in HOLD.
    rdy_pct = 0;
    step(0, '0);
    step(0, '0);
    #1 check("hold2_imem_req", 32'(imem_req), 32'd0);
    step(1, 16'h0200);
    rdy_pct = 100;
    repeat (4) step(0, '0);

    // Redirect while a request is outstanding.
    lat_min = 2; lat_max = 2;
    redir_on_wait = 1; redir_on_wait_tgt = 16'h0100;
    repeat (12) step(0, '0);

    // Randomized traffic.
    lat_min = 0; lat_max = 3; rdy_pct = 70; redir_pct = 4;
    repeat (3000) step(0, '0);

    // Reset in the middle of an outstanding request.
    redir_pct = 0; rdy_pct = 100; lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, '0);
      if (imem_req && !imem_ready) found = 1;
    end
    check("mid_request_reached", 32'(found), 32'd1);
    @(negedge clock);
    reset = 1'b0; mem_busy = 0; imem_ready = 1'b0; redirect_valid = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    lat_min = 0; lat_max = 0;
    step(0, '0);
    #1;
    check("restart_imem_req", 32'(imem_req), 32'd1);
    check("restart_imem_addr", 32'(imem_addr), 32'(RST_PC));
    repeat (20) step(0, '0);

    check("liveness", 32'(accepted > 300), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- monitor / reference model ----------------
  logic [AB-1:0] exp_q[$];
  logic [AB-1:0] next_fetch;
  bit            pend_v = 0;
  logic [AB-1:0] pend_t;
  bit            exp_next_v = 0;
  logic [AB-1:0] exp_next;
  bit            flush_chk = 0;
  bit            prev_wait = 0;
  logic [AB-1:0] prev_addr;

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_fetch);
      next_fetch = next_fetch + 16'd4;
    end
  endtask

  initial begin
    logic [AB-1:0] pcx;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        exp_q.delete();
        next_fetch = RST_PC;
        refill();
        pend_v = 0; exp_next_v = 0; flush_chk = 0; prev_wait = 0;
        continue;
      end
      if (exp_next_v) begin
        check("redirect_req", 32'(imem_req), 32'd1);
        check("redirect_addr", 32'(imem_addr), 32'(exp_next));
        exp_next_v = 0;
      end
      if (flush_chk) begin
        check("flush_instr_valid", 32'(instr_valid), 32'd0);
        flush_chk = 0;
      end
      if (prev_wait) begin
        check("stable_req", 32'(imem_req), 32'd1);
        check("stable_addr", 32'(imem_addr), 32'(prev_addr));
      end
      if (instr_valid && instr_ready) begin
        pcx = exp_q.pop_front();
        $display("accept pc=%h instr=%h (expected pc=%h)", instr_pc, instr, pcx);
        check("instr_pc", 32'(instr_pc), 32'(pcx));
        check("instr", instr, mem_word(pcx));
        accepted++;
        refill();
      end
      if (redirect_valid) begin
        if (imem_req && !imem_ready) begin
          pend_v = 1;
          pend_t = redirect_target;
        end else begin
          pend_v     = 0;
          exp_next_v = 1;
          exp_next   = redirect_target;
        end
        flush_chk = 1;
        exp_q.delete();
        next_fetch = redirect_target;
        refill();
      end else if (pend_v && imem_req && imem_ready) begin
        pend_v     = 0;
        exp_next_v = 1;
        exp_next   = pend_t;
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
  end

endmodule

// File: doc/fetch_control.md
# fetch_control

Sequencer for the fetch stage: drives `fetch`'s `next_PC_select`/`target_PC` to advance, hold or redirect the PC, runs the instruction-memory request/ready handshake, and presents fetched instructions to decode through a one-entry valid/ready output buffer. It sits between `fetch`, instruction memory and decode, and is the only place in the core where branch/jump redirects are applied to the PC.

## Interface
- `ADDRESS_BITS`, 16, PC/address width (byte addresses)
- `RESET_PC`, 0, first fetch address after reset
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `PC`  in  ADDRESS_BITS  current PC from `fetch`
- `next_PC_select`  out  1  1: `fetch` loads `target_PC`; 0: `fetch` loads PC+4
- `target_PC`  out  ADDRESS_BITS  PC load value
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDRESS_BITS  request address (= `PC`)
- `imem_ready`  in  1  response valid this cycle, completes request
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  taken branch/jump from execute, single-cycle pulse
- `redirect_target`  in  ADDRESS_BITS  redirect address
- `instr_valid`  out  1  output buffer holds an instruction
- `instr_ready`  in  1  decode accepts
- `instr`  out  32  instruction
- `instr_pc`  out  ADDRESS_BITS  its address

## Operation
- States: BOOT, REQ, HOLD.
- BOOT (reset state, one cycle): `next_PC_select`=1, `target_PC`=`RESET_PC`; `imem_req`=0; -> REQ.
- REQ: `imem_req`=1, `imem_addr`=`PC`; `imem_req`/`imem_addr` stay stable until `imem_ready`. While waiting, PC held (`next_PC_select`=1, `target_PC`=`PC`).
- On `imem_ready` in REQ, no pending redirect: if buffer empty or drained this cycle (`instr_valid && instr_ready`), capture {`imem_rdata`,`PC`}, `next_PC_select`=0 (PC+4), stay REQ; else -> HOLD with PC held.
- HOLD: `imem_req`=0, PC held, response stored in a side register; when the buffer drains, move it to the buffer, advance PC, -> REQ.
- Redirect (priority over everything): if no request outstanding (BOOT, HOLD, or REQ with `imem_ready` the same cycle), apply immediately: `next_PC_select`=1, `target_PC`=`redirect_target`, flush buffer and side register, any same-cycle response discarded, -> REQ. If a request is outstanding in REQ without `imem_ready`, latch target in `pend_redirect`; the eventual response is discarded and the latched target loaded that cycle.
- Second redirect while pending: newer target overwrites.
- Unaligned `redirect_target` accepted as-is; low two bits not checked.
- PC+4 wraps modulo 2^ADDRESS_BITS (computed in `fetch`).

## Timing
- Reset (async assert, sync release): state BOOT, `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `pend_redirect` clear, `next_PC_select`=1, `target_PC`=`RESET_PC`.
- First `imem_req` one cycle after reset release, address `RESET_PC`.
- Zero-wait memory (`imem_ready` same cycle as `imem_req`), decode always ready: one instruction per cycle, `instr_valid` one cycle after `imem_ready`.
- Redirect to first `imem_req` at new target: 1 cycle if no request outstanding, otherwise 1 cycle after the outstanding `imem_ready`.
- `next_PC_select`, `target_PC`, `imem_req`, `imem_addr` combinational from state, `PC` and inputs; `instr*` registered.

## Configuration
- `FETCH_CONTROL_PERF_EN` defined: adds outputs `perf_fetched` (32, count of instructions written to buffer) and `perf_stall` (32, cycles in REQ without `imem_ready` plus cycles in HOLD); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `fetch_control_pkg`: state enum {BOOT, REQ, HOLD}, `INSTR_BITS`=32, `PC_STEP`=4.
- Sub-module `fetch_out_buffer`: one-entry valid/ready register with flush, holds {instr, instr_pc}.

## Test plan
- Reset low 3 cycles then high, zero-wait memory, `instr_ready`=1 -> `imem_addr` 0x0000, 0x0004, 0x0008 on consecutive cycles; `instr_pc` follows one cycle later.
- `imem_ready` delayed 3 cycles at PC 0x0010 -> `imem_addr` stable at 0x0010 for 4 cycles, PC held, single `instr_valid` for 0x0010.
- `instr_ready`=0 for 4 cycles with buffer full -> next response parked in HOLD, no duplicate/lost instruction, order preserved when released.
- `redirect_valid` with target 0x0100 while request to 0x0020 outstanding (ready 2 cycles later) -> 0x0020 response dropped, next `imem_addr` 0x0100, no `instr_valid` for 0x0020.
- Redirect to 0x0200 in HOLD -> buffer flushed (`instr_valid`=0 next cycle), next fetch 0x0200.
- Reset asserted mid-request -> all outputs to reset values immediately; after release fetch restarts at `RESET_PC`; with `FETCH_CONTROL_PERF_EN`, counters read 0.
